// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between fetch and load/store ports, with an ack watchdog.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise data has fixed priority.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic          if_err,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic          d_err,
    output logic [DW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_t;
    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          if_done_q, if_done_d, if_err_q, if_err_d;
    logic          d_done_q, d_done_d, d_err_q, d_err_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic          pick_data, fin, grant_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
    // last_q=1 means data was granted last, so fetch wins the next tie
    assign pick_data = d_req && (!if_req || !last_q);
    assign last_d    = (state_q == IDLE && (if_req || d_req)) ? pick_data : last_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) last_q <= 1'b1;
        else        last_q <= last_d;
`else
    assign pick_data = d_req;
`endif

    assign fin     = mem_ack || cnt_q == LAST_CNT;
    assign grant_d = state_q == GNT_D;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_done_d   = 1'b0;
        if_err_d    = 1'b0;
        d_done_d    = 1'b0;
        d_err_d     = 1'b0;
        case (state_q)
            IDLE: if (if_req || d_req) begin
                state_d     = pick_data ? GNT_D : GNT_I;
                mem_req_d   = 1'b1;
                mem_we_d    = pick_data && d_we;
                mem_addr_d  = pick_data ? d_addr : if_addr;
                mem_wdata_d = pick_data ? d_wdata : '0;
            end
            GNT_I, GNT_D: if (fin) begin
                state_d    = RESP;
                mem_req_d  = 1'b0;
                if_done_d  = !grant_d;
                d_done_d   = grant_d;
                if_err_d   = !grant_d && !mem_ack;
                d_err_d    = grant_d && !mem_ack;
                if_rdata_d = (!grant_d && mem_ack) ? mem_rdata : if_rdata_q;
                d_rdata_d  = (grant_d && mem_ack) ? mem_rdata : d_rdata_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_done_q    <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_done_q   <= if_done_d;
            if_err_q    <= if_err_d;
            if_rdata_q  <= if_rdata_d;
            d_done_q    <= d_done_d;
            d_err_q     <= d_err_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_done   = if_done_q;
    assign if_err    = if_err_q;
    assign if_rdata  = if_rdata_q;
    assign d_done    = d_done_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model.
// Honours ARB_ROUND_ROBIN_EN in the same way as the design.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, d_req, d_we, mem_ack;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic          if_done, if_err, d_done, d_err, mem_req, mem_we;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    int          checks = 0;
    int          errors = 0;
    logic        m_last;
    logic [31:0] m_if_rd, m_d_rd;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_err(if_err), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Model: returns 1 when the data port should win the grant
    function automatic logic model_pick_data(input logic i, input logic d);
        if (i && d) begin
`ifdef ARB_ROUND_ROBIN_EN
            return m_last == 1'b0;
`else
            return 1'b1;
`endif
        end
        return d;
    endfunction

    task automatic test_reset();
        logic dw;
        m_last = 1'b1; m_if_rd = '0; m_d_rd = '0;
        rst_n = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        if_addr = 32'h1111; d_addr = 32'h2222; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, if_done, if_err, if_rdata, d_done, d_err, d_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h expected 0",
                     {mem_req, mem_we, mem_addr, mem_wdata, if_done, if_err, if_rdata, d_done, d_err, d_rdata});
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_release_req got %b expected 0", mem_req); end
        @(negedge clk);
        dw = model_pick_data(1'b1, 1'b1);
        m_last = dw;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== (dw ? d_addr : if_addr)) begin
            errors++;
            $display("FAIL reset_first_grant got req=%b addr=%h expected req=1 addr=%h", mem_req, mem_addr, dw ? d_addr : if_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'hA5A5_0001;
        @(negedge clk);
        mem_ack = 1'b0;
        if (dw) m_d_rd = 32'hA5A5_0001; else m_if_rd = 32'hA5A5_0001;
        checks++;
        if ({if_done, d_done} !== {!dw, dw} || if_rdata !== m_if_rd || d_rdata !== m_d_rd) begin
            errors++;
            $display("FAIL reset_first_done got if_done=%b d_done=%b expected %b %b", if_done, d_done, !dw, dw);
        end
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || if_done !== 1'b0) begin
            errors++;
            $display("FAIL fetch_mem got req=%b addr=%h we=%b expected 1 100 0", mem_req, mem_addr, mem_we);
        end
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        mem_ack = 1'b0;
        m_if_rd = 32'hDEADBEEF; m_last = 1'b0;
        checks++;
        if (if_done !== 1'b1 || if_err !== 1'b0 || if_rdata !== 32'hDEADBEEF || d_done !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL fetch_done got done=%b err=%b rdata=%h expected 1 0 deadbeef", if_done, if_err, if_rdata);
        end
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if (if_done !== 1'b0 || if_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL fetch_hold got done=%b rdata=%h expected 0 deadbeef", if_done, if_rdata);
        end
    endtask

    task automatic test_store();
        logic [31:0] rd;
        rd = $urandom;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h12345678;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h2000 || mem_wdata !== 32'h12345678 ||
                d_done !== 1'b0 || if_done !== 1'b0) begin
                errors++;
                $display("FAIL store_hold cycle %0d got req=%b we=%b addr=%h wdata=%h expected 1 1 2000 12345678",
                         k, mem_req, mem_we, mem_addr, mem_wdata);
            end
            if (k == 4) begin mem_ack = 1'b1; mem_rdata = rd; end
        end
        @(negedge clk);
        mem_ack = 1'b0;
        m_d_rd = rd; m_last = 1'b1;
        checks++;
        if (d_done !== 1'b1 || d_err !== 1'b0 || if_done !== 1'b0 || mem_req !== 1'b0 || d_rdata !== m_d_rd) begin
            errors++;
            $display("FAIL store_done got d_done=%b d_err=%b if_done=%b req=%b expected 1 0 0 0", d_done, d_err, if_done, mem_req);
        end
        d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_tie();
        logic dw;
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 32'h1111; d_addr = 32'h2222;
        for (int n = 0; n < 6; n++) begin
            dw = model_pick_data(1'b1, 1'b1);
            m_last = dw;
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== (dw ? d_addr : if_addr)) begin
                errors++;
                $display("FAIL tie_grant %0d got addr=%h expected %h", n, mem_addr, dw ? d_addr : if_addr);
            end
            mem_ack = 1'b1; mem_rdata = 32'h7700 + n;
            @(negedge clk);
            mem_ack = 1'b0;
            if (dw) m_d_rd = 32'h7700 + n; else m_if_rd = 32'h7700 + n;
            checks++;
            if ({if_done, d_done} !== {!dw, dw} || if_rdata !== m_if_rd || d_rdata !== m_d_rd) begin
                errors++;
                $display("FAIL tie_done %0d got if_done=%b d_done=%b expected %b %b", n, if_done, d_done, !dw, dw);
            end
            @(negedge clk);
        end
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000;
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b1 || d_done !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait cycle %0d got req=%b done=%b expected 1 0", k, mem_req, d_done);
            end
        end
        @(negedge clk);
        m_last = 1'b1;
        checks++;
        if (mem_req !== 1'b0 || d_done !== 1'b1 || d_err !== 1'b1 || d_rdata !== m_d_rd) begin
            errors++;
            $display("FAIL timeout_abort got req=%b done=%b err=%b rdata=%h expected 0 1 1 %h", mem_req, d_done, d_err, d_rdata, m_d_rd);
        end
        d_req = 1'b0;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        mem_ack = 1'b0;
        checks++;
        if (if_done !== 1'b0 || d_done !== 1'b0 || mem_req !== 1'b0 || d_rdata !== m_d_rd || if_rdata !== m_if_rd) begin
            errors++;
            $display("FAIL stray_ack got if_done=%b d_done=%b req=%b expected 0 0 0", if_done, d_done, mem_req);
        end
        if_req = 1'b1; if_addr = 32'h180;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        mem_ack = 1'b0;
        m_if_rd = 32'hCAFEF00D; m_last = 1'b0;
        checks++;
        if (if_done !== 1'b1 || if_err !== 1'b0 || if_rdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL timeout_recover got done=%b err=%b rdata=%h expected 1 0 cafef00d", if_done, if_err, if_rdata);
        end
        if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        if_req = 1'b1; if_addr = 32'h300; d_req = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_grant got req=%b expected 1", mem_req); end
        #2 rst_n = 1'b0;
        #1;
        m_last = 1'b1; m_if_rd = '0; m_d_rd = '0;
        checks++;
        if (mem_req !== 1'b0 || if_done !== 1'b0 || if_rdata !== '0 || d_rdata !== '0) begin
            errors++;
            $display("FAIL mid_async got req=%b done=%b rdata=%h expected 0 0 0", mem_req, if_done, if_rdata);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || if_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_held got req=%b done=%b expected 0 0", mem_req, if_done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        m_last = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h300 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL mid_restart got req=%b addr=%h expected 1 300", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h0BADC0DE;
        @(negedge clk);
        mem_ack = 1'b0;
        m_if_rd = 32'h0BADC0DE;
        checks++;
        if (if_done !== 1'b1 || if_err !== 1'b0 || if_rdata !== m_if_rd) begin
            errors++;
            $display("FAIL mid_done got done=%b rdata=%h expected 1 %h", if_done, if_rdata, m_if_rd);
        end
        if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic dw, ewe, eerr;
        logic [31:0] ea, ed, rd;
        int lat;
        rd = '0;
        for (int n = 0; n < 40; n++) begin
            if (!if_req) begin if_req = 1'($urandom_range(0, 1)); if_addr = $urandom; end
            if (!d_req) begin
                d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
                d_addr = $urandom; d_wdata = $urandom;
            end
            if (!if_req && !d_req) begin
                @(negedge clk);
                checks++;
                if (mem_req !== 1'b0) begin errors++; $display("FAIL rnd_idle %0d got req=%b expected 0", n, mem_req); end
                continue;
            end
            dw  = model_pick_data(if_req, d_req);
            ea  = dw ? d_addr : if_addr;
            ewe = dw && d_we;
            ed  = d_wdata;
            m_last = dw;
            lat = $urandom_range(1, TO + 2);
            eerr = lat > TO;
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                if (dw) d_req = 1'b0; else if_req = 1'b0;
            end
            for (int k = 1; k <= TO; k++) begin
                checks++;
                if (mem_req !== 1'b1 || mem_addr !== ea || mem_we !== ewe || (ewe && mem_wdata !== ed) ||
                    if_done !== 1'b0 || d_done !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_access %0d.%0d got req=%b addr=%h we=%b wdata=%h expected 1 %h %b %h",
                             n, k, mem_req, mem_addr, mem_we, mem_wdata, ea, ewe, ed);
                end
                if (k == lat) begin mem_ack = 1'b1; rd = $urandom; mem_rdata = rd; end
                @(negedge clk);
                mem_ack = 1'b0;
                if (k == lat) break;
            end
            if (!eerr) begin
                if (dw) m_d_rd = rd; else m_if_rd = rd;
            end
            checks++;
            if ({if_done, if_err, d_done, d_err} !== {!dw, !dw && eerr, dw, dw && eerr} ||
                if_rdata !== m_if_rd || d_rdata !== m_d_rd || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL rnd_done %0d got flags=%b rd=%h/%h expected flags=%b rd=%h/%h", n,
                         {if_done, if_err, d_done, d_err}, if_rdata, d_rdata,
                         {!dw, !dw && eerr, dw, dw && eerr}, m_if_rd, m_d_rd);
            end
            if (dw) d_req = 1'b0; else if_req = 1'b0;
            @(negedge clk);
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_tie();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
